// File: rtl/counter_nbit_updown_mod_pkg.sv
// Shared definitions for the counter family: direction encoding and load clamping.
package counter_pkg;

  typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;

  localparam int unsigned CNT_MAX_WIDTH = 32;

  // Callers zero-extend their operands to 32 bits and truncate the result back.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/counter_nbit_updown_mod_if.sv
// Control/status bundle for the up/down modulo counter.
interface counter_nbit_updown_mod_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  Q, tc, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output Q, tc, wrap
  );
endinterface

// File: rtl/counter_nbit_updown_mod_bound_detect.sv
// Combinational boundary detection for a 0..MAX_VAL counter; tc follows direction.
module counter_bound_detect #(
  parameter int               WIDTH   = 3,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc
);

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign tc      = up_dn ? at_max : at_zero;

endmodule

// File: rtl/counter_nbit_updown_mod.sv
// Runtime-direction modulo (MAX_VAL+1) up/down counter with clamped parallel load.
// Optional macro COUNTER_SATURATE_EN: hold at the boundaries instead of wrapping.
module counter_nbit_updown_mod
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic                       clock,
  input logic                       resetn,
  counter_nbit_updown_mod_if.slave  cnt
);

  if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
    $error("counter_nbit_updown_mod: WIDTH out of range");
  end
  if (MAX_VAL == '0 || INIT_VAL > MAX_VAL) begin : g_bad_range
    $error("counter_nbit_updown_mod: MAX_VAL/INIT_VAL out of range");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] q_load;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             at_max;
  logic             at_zero;
  cnt_dir_e         dir;

  assign dir    = cnt_dir_e'(cnt.up_dn);
  assign q_load = WIDTH'(clamp_load(32'(cnt.load_val), 32'(MAX_VAL)));

  counter_bound_detect #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_bound (
    .q       (q_r),
    .up_dn   (cnt.up_dn),
    .at_max  (at_max),
    .at_zero (at_zero),
    .tc      (cnt.tc)
  );

  always_comb begin
    q_nxt    = q_r;
    wrap_nxt = 1'b0;
    if (cnt.load) begin
      q_nxt = q_load;
    end else if (cnt.en) begin
      if (dir == CNT_UP) begin
        if (at_max) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt    = q_r;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q_r + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
          q_nxt    = q_r;
`else
          q_nxt    = MAX_VAL;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = q_r - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q_r    <= INIT_VAL;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign cnt.Q    = q_r;
  assign cnt.wrap = wrap_r;

endmodule
